// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage access unit (master) and the data memory (slave).
interface mem_access_unit_if;
  logic        o_dbus_req;
  logic        o_dbus_we;
  logic [31:0] o_dbus_addr;
  logic [31:0] o_dbus_wdata;
  logic [3:0]  o_dbus_strb;
  logic        i_dbus_ack;
  logic [31:0] i_dbus_rdata;

  modport master (
    output o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_strb,
    input  i_dbus_ack, i_dbus_rdata
  );

  modport slave (
    input  o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_strb,
    output i_dbus_ack, i_dbus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM control into one req/ack bus transaction and stalls the pipe.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_mem_mem_read,
  input  logic        i_mem_mem_write,
  input  logic        i_mem_lsb,
  input  logic        i_mem_lsh,
  input  logic        i_mem_load_signext,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_data_mem,
  mem_access_unit_if.master dbus,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_bus_err,
  output logic        o_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic        byte_q;
  logic        half_q;
  logic        signext_q;
  logic [1:0]  off_q;
  logic [31:0] timeout_cnt;

  logic        access;
  logic [3:0]  strb_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic        timeout_hit;

  assign access      = i_mem_mem_read | i_mem_mem_write;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_cnt == TIMEOUT_CYCLES - 1);
  assign o_stall     = resetn && ((state == IDLE && access) || state == REQ);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (!i_mem_lsb && i_mem_lsh && i_mem_addr[0]) ||
                      (!i_mem_lsb && !i_mem_lsh && (i_mem_addr[1:0] != 2'b00));
`else
  assign o_misalign = 1'b0;
`endif

  // Byte access wins when both size bits are set; reads never assert strobes.
  always_comb begin
    strb_next  = 4'b1111;
    wdata_next = i_mem_data_mem;
    if (i_mem_lsb) begin
      strb_next  = 4'b0001 << i_mem_addr[1:0];
      wdata_next = {4{i_mem_data_mem[7:0]}};
    end else if (i_mem_lsh) begin
      strb_next  = i_mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{i_mem_data_mem[15:0]}};
    end
    if (!i_mem_mem_write) strb_next = 4'b0000;
  end

  always_comb begin
    byte_lane = dbus.i_dbus_rdata[7:0];
    case (off_q)
      2'd1:    byte_lane = dbus.i_dbus_rdata[15:8];
      2'd2:    byte_lane = dbus.i_dbus_rdata[23:16];
      2'd3:    byte_lane = dbus.i_dbus_rdata[31:24];
      default: byte_lane = dbus.i_dbus_rdata[7:0];
    endcase
    half_lane = off_q[1] ? dbus.i_dbus_rdata[31:16] : dbus.i_dbus_rdata[15:0];
    load_ext  = dbus.i_dbus_rdata;
    if (byte_q)
      load_ext = {{24{signext_q & byte_lane[7]}}, byte_lane};
    else if (half_q)
      load_ext = {{16{signext_q & half_lane[15]}}, half_lane};
  end

  // Bus outputs are latched on leaving IDLE so they stay stable for the whole request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      dbus.o_dbus_req   <= 1'b0;
      dbus.o_dbus_we    <= 1'b0;
      dbus.o_dbus_addr  <= '0;
      dbus.o_dbus_wdata <= '0;
      dbus.o_dbus_strb  <= '0;
      byte_q            <= 1'b0;
      half_q            <= 1'b0;
      signext_q         <= 1'b0;
      off_q             <= '0;
      timeout_cnt       <= '0;
      o_load_data       <= '0;
      o_bus_err         <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      o_misalign        <= 1'b0;
`endif
    end else begin
      o_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      o_misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access) begin
            dbus.o_dbus_addr  <= {i_mem_addr[31:2], 2'b00};
            dbus.o_dbus_we    <= i_mem_mem_write;
            dbus.o_dbus_wdata <= wdata_next;
            dbus.o_dbus_strb  <= strb_next;
            byte_q            <= i_mem_lsb;
            half_q            <= !i_mem_lsb && i_mem_lsh;
            signext_q         <= i_mem_load_signext;
            off_q             <= i_mem_addr[1:0];
            timeout_cnt       <= '0;
`ifdef MISALIGN_TRAP_EN
            if (misaligned) begin
              state       <= DONE;
              o_misalign  <= 1'b1;
              o_load_data <= '0;
            end else begin
              state           <= REQ;
              dbus.o_dbus_req <= 1'b1;
            end
`else
            state           <= REQ;
            dbus.o_dbus_req <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (dbus.i_dbus_ack) begin
            if (!dbus.o_dbus_we) o_load_data <= load_ext;
            dbus.o_dbus_req <= 1'b0;
            state           <= DONE;
          end else if (timeout_hit) begin
            o_load_data     <= '0;
            o_bus_err       <= 1'b1;
            dbus.o_dbus_req <= 1'b0;
            state           <= DONE;
          end else begin
            timeout_cnt <= timeout_cnt + 32'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset/idle corner sequences, random traffic.
// Define MISALIGN_TRAP_EN for both bench and RTL to exercise the misalignment trap build.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        resetn;
  logic        i_mem_mem_read;
  logic        i_mem_mem_write;
  logic        i_mem_lsb;
  logic        i_mem_lsh;
  logic        i_mem_load_signext;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_data_mem;
  logic        o_stall;
  logic [31:0] o_load_data;
  logic        o_bus_err;
  logic        o_misalign;

  mem_access_unit_if dbus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .i_mem_mem_read     (i_mem_mem_read),
    .i_mem_mem_write    (i_mem_mem_write),
    .i_mem_lsb          (i_mem_lsb),
    .i_mem_lsh          (i_mem_lsh),
    .i_mem_load_signext (i_mem_load_signext),
    .i_mem_addr         (i_mem_addr),
    .i_mem_data_mem     (i_mem_data_mem),
    .dbus               (dbus),
    .o_stall            (o_stall),
    .o_load_data        (o_load_data),
    .o_bus_err          (o_bus_err),
    .o_misalign         (o_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        lsb;
    logic        lsh;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] load;
    logic        err;
    logic        misal;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] tracked_load = 32'h0;
  vec_t        tbl [13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: size in bytes, effective lane offset, and lane-level arithmetic.
  function automatic int sizeOf(input logic lsb, input logic lsh);
    return lsb ? 1 : (lsh ? 2 : 4);
  endfunction

  function automatic int offOf(input logic [31:0] addr, input int n);
    if (n == 1) return int'(addr % 4);
    if (n == 2) return int'(addr % 4) / 2 * 2;
    return 0;
  endfunction

  function automatic logic [3:0] modelStrb(input logic wr, input logic lsb, input logic lsh, input logic [31:0] addr);
    int n = sizeOf(lsb, lsh);
    int v = ((1 << n) - 1) << offOf(addr, n);
    return wr ? v[3:0] : 4'b0000;
  endfunction

  function automatic logic [31:0] modelWdata(input logic lsb, input logic lsh, input logic [31:0] d);
    int n = sizeOf(lsb, lsh);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = d[(i % n)*8 +: 8];
    return w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic lsb, input logic lsh, input logic sx,
                                            input logic [31:0] addr, input logic [31:0] rdata);
    int n = sizeOf(lsb, lsh);
    logic [31:0] mask;
    logic [31:0] v;
    if (n == 4) return rdata;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rdata >> (8 * offOf(addr, n))) & mask;
    if (sx && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit isMisaligned(input logic lsb, input logic lsh, input logic [31:0] addr);
    int n = sizeOf(lsb, lsh);
    return (addr % n) != 0;
  endfunction

  task automatic clearInputs();
    i_mem_mem_read     = 1'b0;
    i_mem_mem_write    = 1'b0;
    i_mem_lsb          = 1'b0;
    i_mem_lsh          = 1'b0;
    i_mem_load_signext = 1'b0;
    i_mem_addr         = '0;
    i_mem_data_mem     = '0;
  endtask

  // One full transaction: IDLE cycle, REQ cycles (ack after 'waits' wait states or timeout), DONE, back to IDLE.
  task automatic applyStimulus(input logic rd, input logic wr, input logic lsb, input logic lsh, input logic sx,
                               input logic [31:0] addr, input logic [31:0] data, input int waits,
                               input logic [31:0] rdata, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                               input logic [31:0] e_load, input logic e_err);
    int  stalls = 0;
    bit  timeout = (waits >= TO);
    int  req_cycles = timeout ? TO : waits + 1;
    @(negedge clk);
    i_mem_mem_read = rd; i_mem_mem_write = wr; i_mem_lsb = lsb; i_mem_lsh = lsh;
    i_mem_load_signext = sx; i_mem_addr = addr; i_mem_data_mem = data;
    dbus.i_dbus_ack = 1'b0;
    #1;
    if (o_stall) stalls++;
    checkOutput("idle_req", 32'(dbus.o_dbus_req), 32'd0);
    for (int c = 0; c < req_cycles; c++) begin
      @(negedge clk);
      dbus.i_dbus_ack = 1'b0;
      if (!timeout && c == waits) begin
        dbus.i_dbus_ack   = 1'b1;
        dbus.i_dbus_rdata = rdata;
      end else begin
        dbus.i_dbus_rdata = $urandom;
      end
      #1;
      if (o_stall) stalls++;
      checkOutput("req_high", 32'(dbus.o_dbus_req), 32'd1);
      checkOutput("req_addr", dbus.o_dbus_addr, {addr[31:2], 2'b00});
      checkOutput("req_we", 32'(dbus.o_dbus_we), 32'(wr));
      checkOutput("req_strb", 32'(dbus.o_dbus_strb), 32'(e_strb));
      if (wr) checkOutput("req_wdata", dbus.o_dbus_wdata, e_wdata);
    end
    @(negedge clk);
    dbus.i_dbus_ack   = 1'b0;
    dbus.i_dbus_rdata = $urandom;
    #1;
    if (o_stall) stalls++;
    checkOutput("done_req", 32'(dbus.o_dbus_req), 32'd0);
    checkOutput("done_load", o_load_data, e_load);
    checkOutput("done_bus_err", 32'(o_bus_err), 32'(e_err));
    checkOutput("done_misalign", 32'(o_misalign), 32'd0);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("after_req", 32'(dbus.o_dbus_req), 32'd0);
    checkOutput("after_stall", 32'(o_stall), 32'd0);
    checkOutput("after_bus_err", 32'(o_bus_err), 32'd0);
    checkOutput("stall_cycles", 32'(stalls), 32'(req_cycles + 1));
    tracked_load = e_load;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] e_load;
    logic        e_err;
    //           rd   wr   lsb  lsh  sx   addr          data          w  rdata         strb     wdata         load          err  misal
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0000_1003,32'h0000_00AB,0,32'h0,        4'b1000,32'hABAB_ABAB,32'h0,        1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,32'h0000_2002,32'h0,        1,32'h0080_0000,4'b0000,32'h0,        32'hFFFF_FF80,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_1002,32'hFFFF_1234,0,32'h0,        4'b1100,32'h1234_1234,32'h0,        1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_2002,32'h0,        0,32'hBEEF_1234,4'b0000,32'h0,        32'h0000_BEEF,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_3003,32'h0,        2,32'hCAFE_F00D,4'b0000,32'h0,        32'hCAFE_F00D,1'b0,1'b1};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_4000,32'h1122_3344,0,32'h0,        4'b1111,32'h1122_3344,32'h0,        1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h0000_2001,32'h0,        0,32'h0000_8001,4'b0000,32'h0,        32'hFFFF_8001,1'b0,1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_2001,32'h0,        0,32'h0000_A500,4'b0000,32'h0,        32'h0000_00A5,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0000_0010,32'h0000_005A,3,32'h0,        4'b0001,32'h5A5A_5A5A,32'h0,        1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_2000,32'h0,        4,32'h1234_5678,4'b0000,32'h0,        32'h0,        1'b1,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b1,32'h0000_2003,32'h0,        0,32'h7F00_0000,4'b0000,32'h0,        32'h0000_007F,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h0000_2002,32'h0,        1,32'h9000_0000,4'b0000,32'h0,        32'hFFFF_9000,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_1001,32'h0000_BEEF,0,32'h0,        4'b0011,32'hBEEF_BEEF,32'h0,        1'b0,1'b1};

    resetn = 1'b0;
    clearInputs();
    i_mem_mem_read    = 1'b1;
    dbus.i_dbus_ack   = 1'b0;
    dbus.i_dbus_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_req", 32'(dbus.o_dbus_req), 32'd0);
    checkOutput("rst_stall", 32'(o_stall), 32'd0);
    checkOutput("rst_load", o_load_data, 32'd0);
    checkOutput("rst_bus_err", 32'(o_bus_err), 32'd0);
    checkOutput("rst_misalign", 32'(o_misalign), 32'd0);
    checkOutput("rst_strb", 32'(dbus.o_dbus_strb), 32'd0);
    checkOutput("rst_addr", dbus.o_dbus_addr, 32'd0);
    @(negedge clk);
    clearInputs();
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
`ifdef MISALIGN_TRAP_EN
      if (tbl[i].misal) continue;
`endif
      if (tbl[i].err)     e_load = 32'h0;
      else if (tbl[i].wr) e_load = tracked_load;
      else                e_load = tbl[i].load;
      applyStimulus(tbl[i].rd, tbl[i].wr, tbl[i].lsb, tbl[i].lsh, tbl[i].sx, tbl[i].addr, tbl[i].data,
                    tbl[i].waits, tbl[i].rdata, tbl[i].strb, tbl[i].wdata, e_load, tbl[i].err);
    end

    // Ack with no access pending must not start anything or disturb the load result.
    @(negedge clk);
    dbus.i_dbus_ack   = 1'b1;
    dbus.i_dbus_rdata = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("stray_ack_req", 32'(dbus.o_dbus_req), 32'd0);
      checkOutput("stray_ack_stall", 32'(o_stall), 32'd0);
      checkOutput("stray_ack_load", o_load_data, tracked_load);
    end
    dbus.i_dbus_ack = 1'b0;

    // Reset asserted in the middle of a request drops req and stall immediately.
    @(negedge clk);
    i_mem_mem_read = 1'b1; i_mem_addr = 32'h0000_5000;
    @(negedge clk);
    #1;
    checkOutput("midrst_req_before", 32'(dbus.o_dbus_req), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_req", 32'(dbus.o_dbus_req), 32'd0);
    checkOutput("midrst_stall", 32'(o_stall), 32'd0);
    checkOutput("midrst_load", o_load_data, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    clearInputs();
    #1;
    checkOutput("postrst_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("postrst_req", 32'(dbus.o_dbus_req), 32'd0);
    tracked_load = 32'h0;

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    i_mem_mem_read = 1'b1; i_mem_addr = 32'h0000_1002;
    #1;
    checkOutput("trap_idle_stall", 32'(o_stall), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("trap_done_req", 32'(dbus.o_dbus_req), 32'd0);
    checkOutput("trap_done_stall", 32'(o_stall), 32'd0);
    checkOutput("trap_misalign", 32'(o_misalign), 32'd1);
    checkOutput("trap_load", o_load_data, 32'd0);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("trap_misalign_clear", 32'(o_misalign), 32'd0);
    tracked_load = 32'h0;
`endif

    for (int k = 0; k < 150; k++) begin
      logic        rd, wr, lsb, lsh, sx;
      logic [31:0] addr, data, rdata;
      int          waits, kind;
      kind  = $urandom_range(0, 2);
      rd    = (kind != 1);
      wr    = (kind != 0);
      lsb   = 1'($urandom_range(0, 1));
      lsh   = 1'($urandom_range(0, 1));
      sx    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      data  = $urandom;
      rdata = $urandom;
      waits = $urandom_range(0, 5);
`ifdef MISALIGN_TRAP_EN
      if (isMisaligned(lsb, lsh, addr)) addr = addr - (addr % sizeOf(lsb, lsh));
`endif
      e_err = (waits >= TO);
      if (e_err)   e_load = 32'h0;
      else if (wr) e_load = tracked_load;
      else         e_load = modelLoad(lsb, lsh, sx, addr, rdata);
      applyStimulus(rd, wr, lsb, lsh, sx, addr, data, waits, rdata,
                    modelStrb(wr, lsb, lsh, addr), modelWdata(lsb, lsh, data), e_load, e_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
